// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter: pulses tick for one cycle every N clocks.
module uart_baud_tick #(
   parameter int N = 434
) (
   input  logic clc,
   input  logic res,
   input  logic restart,
   output logic tick
);

   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (restart || cnt_q == W'(N - 1)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clc or negedge res) begin
      if (!res) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == W'(N - 1));

endmodule

// File: rtl/uart_transmitter.sv
// Byte-wide valid/ready UART transmitter: start, 8 data bits LSB-first,
// optional even parity, 1 or 2 stop bits.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clc,
   input  logic       res,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       TX,
   output logic       busy
);

   generate
      if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
         $error("uart_transmitter: illegal CLKS_PER_BIT or STOP_BITS");
      end
   endgenerate

   uart_tx_state_t       state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [2:0]           bit_cnt_q;
   logic                 parity_q;
   logic                 tx_q;
   logic                 ready_q;
   logic                 accept;
   logic                 tick;

   assign accept = valid & ready_q;

   uart_baud_tick #(
      .N (CLKS_PER_BIT)
   ) u_baud (
      .clc     (clc),
      .res     (res),
      .restart (accept),
      .tick    (tick)
   );

   // bit_cnt_q indexes data bits in DATA and is reused to count stop bits in STOP.
   always_ff @(posedge clc or negedge res) begin
      if (!res) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (accept) begin
                  shift_q   <= data;
                  parity_q  <= ^data;
                  bit_cnt_q <= '0;
                  tx_q      <= 1'b0;
                  ready_q   <= 1'b0;
                  state_q   <= START;
               end
            end
            START: begin
               if (tick) begin
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                     bit_cnt_q <= '0;
                     if (PARITY_EN != 0) begin
                        tx_q    <= parity_q;
                        state_q <= PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                     bit_cnt_q <= '0;
                     ready_q   <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign TX    = tx_q;
   assign ready = ready_q;
   assign busy  = ~ready_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed and randomized frame checks for two transmitter configurations.
module tb_uart_transmitter;

   localparam int N = 4;

   logic       clk;
   logic       res;
   logic [7:0] data_r  [2];
   logic       valid_r [2];
   logic       tx_w    [2];
   logic       ready_w [2];
   logic       busy_w  [2];

   int par_en [2] = '{0, 1};
   int stop_n [2] = '{1, 2};

   int n_pass  = 0;
   int n_total = 0;

   uart_transmitter #(.CLKS_PER_BIT(N), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
      .clc   (clk),
      .res   (res),
      .data  (data_r[0]),
      .valid (valid_r[0]),
      .ready (ready_w[0]),
      .TX    (tx_w[0]),
      .busy  (busy_w[0])
   );

   uart_transmitter #(.CLKS_PER_BIT(N), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
      .clc   (clk),
      .res   (res),
      .data  (data_r[1]),
      .valid (valid_r[1]),
      .ready (ready_w[1]),
      .TX    (tx_w[1]),
      .busy  (busy_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_idle(input int u, input string tag);
      check($sformatf("%s u%0d TX", tag, u), 32'(tx_w[u]), 32'd1);
      check($sformatf("%s u%0d ready", tag, u), 32'(ready_w[u]), 32'd1);
      check($sformatf("%s u%0d busy", tag, u), 32'(busy_w[u]), 32'd0);
   endtask

   // Starts at a negedge with the unit idle; checks TX on every clock of the frame.
   task automatic run_frame(input int u, input logic [7:0] b, input bit hold,
                            input logic [7:0] nb, input int inject_at, input int abort_at);
      logic q[$];
      int   ones;
      int   nclk;
      q.push_back(1'b0);
      ones = 0;
      for (int k = 0; k < 8; k++) begin
         q.push_back(b[k]);
         ones += int'(b[k]);
      end
      if (par_en[u] != 0) q.push_back(logic'(ones % 2));
      for (int s = 0; s < stop_n[u]; s++) q.push_back(1'b1);
      nclk = q.size() * N;

      valid_r[u] = 1'b1;
      data_r[u]  = b;
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         data_r[u] = nb;
      end else begin
         valid_r[u] = 1'b0;
         data_r[u]  = 8'($urandom);
      end
      for (int i = 0; i < nclk; i++) begin
         if (i == inject_at) begin
            valid_r[u] = 1'b1;
            data_r[u]  = 8'h3C;
         end else if (inject_at >= 0 && i == inject_at + 1) begin
            valid_r[u] = 1'b0;
         end
         if (i == abort_at) begin
            res = 1'b0;
            #1;
            check_idle(u, $sformatf("abort %02h c%0d", b, i));
            return;
         end
         check($sformatf("frame %02h u%0d c%0d TX", b, u, i), 32'(tx_w[u]), 32'(q[i / N]));
         check($sformatf("frame %02h u%0d c%0d busy", b, u, i), 32'(busy_w[u]), 32'd1);
         check($sformatf("frame %02h u%0d c%0d ready", b, u, i), 32'(ready_w[u]), 32'd0);
         @(negedge clk);
      end
      check_idle(u, $sformatf("end %02h", b));
      $display("frame %02h unit %0d: %0d bits, %0d busy clocks", b, u, q.size(), nclk);
   endtask

   initial begin
      res        = 1'b0;
      valid_r[0] = 1'b1;
      valid_r[1] = 1'b1;
      data_r[0]  = 8'hA5;
      data_r[1]  = 8'h5A;

      // Reset held with valid asserted: nothing may start.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_idle(0, $sformatf("reset c%0d", c));
         check_idle(1, $sformatf("reset c%0d", c));
      end
      res        = 1'b1;
      valid_r[0] = 1'b0;
      valid_r[1] = 1'b0;
      @(negedge clk);
      check_idle(0, "post-reset");

      run_frame(0, 8'hA5, 1'b0, 8'h00, -1, -1);

      // Back-to-back: valid stays high, second start bit one idle clock later.
      run_frame(0, 8'h00, 1'b1, 8'hFF, -1, -1);
      run_frame(0, 8'hFF, 1'b0, 8'h00, -1, -1);

      run_frame(1, 8'h07, 1'b0, 8'h00, -1, -1);

      run_frame(0, 8'h55, 1'b0, 8'h00, 10, -1);

      // Reset during data bit 3 (frame bit 4).
      run_frame(0, 8'hF0, 1'b0, 8'h00, -1, 4 * N + 1);
      @(negedge clk);
      check_idle(0, "held reset");
      res = 1'b1;
      @(negedge clk);
      check_idle(0, "after abort");
      run_frame(0, 8'h81, 1'b0, 8'h00, -1, -1);

      for (int r = 0; r < 8; r++) begin
         int u;
         u = int'($urandom_range(1, 0));
         run_frame(u, 8'($urandom), 1'b0, 8'h00,
                   ($urandom_range(1, 0) == 1) ? int'($urandom_range(30, 0)) : -1, -1);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
